// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM fade controller and its channel sequencers.
// The optional fade_done output is enabled by defining PWM_FADE_DONE_EN.
package pwm_ctrl_pkg;

    localparam int FADE_STATE_W = 2;

    typedef enum logic [FADE_STATE_W-1:0] {
        FADE_IDLE = 2'd0,
        FADE_UP   = 2'd1,
        FADE_DOWN = 2'd2
    } fade_state_e;

    // Reset period length is all ones; slice to the pwm_module bit width at the use site.
    localparam logic [31:0] PWM_MAX_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/pwm_fade_channel.sv
// One fade sequencer: FSM, step prescaler and duty/target registers for a single PWM channel.
// With PWM_FADE_DONE_EN defined, a one-cycle fade_done pulse marks completion.
module pwm_fade_channel
    import pwm_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = 3,
    parameter int RATE_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wrap,
    input  logic                 apply,
    input  logic [BIT_WIDTH-1:0] new_max,
    input  logic                 cmd_valid,
    input  logic [BIT_WIDTH-1:0] cmd_target,
    input  logic [RATE_W-1:0]    cmd_rate,
    output logic [BIT_WIDTH-1:0] duty,
    output logic                 busy
`ifdef PWM_FADE_DONE_EN
    ,
    output logic                 fade_done
`endif
);

    fade_state_e          state_q, state_d;
    logic [BIT_WIDTH-1:0] duty_q, duty_d;
    logic [BIT_WIDTH-1:0] target_q, target_d;
    logic [RATE_W-1:0]    presc_q, presc_d;
    logic [RATE_W-1:0]    rate_q, rate_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        presc_d  = presc_q;
        rate_d   = rate_q;
        if (cmd_valid) begin
            // A new command overrides any step due on this edge and retargets from the current duty.
            target_d = cmd_target;
            rate_d   = cmd_rate;
            presc_d  = '0;
            if (cmd_target > duty_q) begin
                state_d = FADE_UP;
            end else if (cmd_target < duty_q) begin
                state_d = FADE_DOWN;
            end else begin
                state_d = FADE_IDLE;
            end
        end else begin
            if (wrap && state_q != FADE_IDLE) begin
                if (presc_q == '0) begin
                    duty_d  = (state_q == FADE_UP) ? duty_q + 1'b1 : duty_q - 1'b1;
                    presc_d = rate_q;
                    if (duty_d == target_q) begin
                        state_d = FADE_IDLE;
                    end
                end else begin
                    presc_d = presc_q - 1'b1;
                end
            end
            if (apply) begin
                if (duty_d > new_max) begin
                    duty_d = new_max;
                end
                if (target_d > new_max) begin
                    target_d = new_max;
                end
                if (duty_d == target_d) begin
                    state_d = FADE_IDLE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FADE_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            presc_q  <= '0;
            rate_q   <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            presc_q  <= presc_d;
            rate_q   <= rate_d;
        end
    end

    assign duty = duty_q;
    assign busy = (state_q != FADE_IDLE);

`ifdef PWM_FADE_DONE_EN
    logic fade_done_q, fade_done_d;

    always_comb begin
        fade_done_d = ((state_q != FADE_IDLE) && (state_d == FADE_IDLE)) ||
                      (cmd_valid && (cmd_target == duty_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_done_q <= 1'b0;
        end else begin
            fade_done_q <= fade_done_d;
        end
    end

    assign fade_done = fade_done_q;
`endif

endmodule

// File: rtl/pwm_fade_controller.sv
// Drives duty/max_value of a bank of pwm_module instances, fading duties glitch-free on period wrap.
// Define PWM_FADE_DONE_EN to add the per-channel fade_done pulse output.
module pwm_fade_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int BIT_WIDTH = 3,
    parameter int RATE_W    = 8,
    localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BIT_WIDTH-1:0]          pwm_counter,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CHAN_W-1:0]             cfg_chan,
    input  logic [BIT_WIDTH-1:0]          cfg_target,
    input  logic [RATE_W-1:0]             cfg_rate,
    input  logic                          cfg_max_wr,
    input  logic [BIT_WIDTH-1:0]          cfg_max,
    output logic [BIT_WIDTH-1:0]          max_value,
    output logic [CHANNELS*BIT_WIDTH-1:0] duty_out,
    output logic [CHANNELS-1:0]           busy
`ifdef PWM_FADE_DONE_EN
    ,
    output logic [CHANNELS-1:0]           fade_done
`endif
);

    logic [BIT_WIDTH-1:0] max_value_q, max_value_d;
    logic [BIT_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 wrap;
    logic                 apply;
    logic                 accept;
    logic [BIT_WIDTH-1:0] target_clamped;

    assign wrap   = (pwm_counter == max_value_q);
    assign apply  = wrap && pending_q;
    assign accept = cfg_valid && cfg_ready_q;
    // Clamp against the max currently in force, even if a new max is written this cycle.
    assign target_clamped = (cfg_target > max_value_q) ? max_value_q : cfg_target;

    always_comb begin
        max_value_d = max_value_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        if (apply) begin
            max_value_d = shadow_q;
            pending_d   = 1'b0;
        end
        if (cfg_max_wr) begin
            shadow_d  = cfg_max;
            pending_d = 1'b1;
        end
        // Ready stays low from the max write until one edge after the new max is applied.
        cfg_ready_d = !pending_q && !cfg_max_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_value_q <= PWM_MAX_RESET[BIT_WIDTH-1:0];
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            max_value_q <= max_value_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign max_value = max_value_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pwm_fade_channel #(
            .BIT_WIDTH(BIT_WIDTH),
            .RATE_W   (RATE_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .wrap      (wrap),
            .apply     (apply),
            .new_max   (shadow_q),
            .cmd_valid (accept && (cfg_chan == CHAN_W'(i))),
            .cmd_target(target_clamped),
            .cmd_rate  (cfg_rate),
            .duty      (duty_out[i*BIT_WIDTH +: BIT_WIDTH]),
            .busy      (busy[i])
`ifdef PWM_FADE_DONE_EN
            ,
            .fade_done (fade_done[i])
`endif
        );
    end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed self-checking bench for pwm_fade_controller: a vector table plus reset corner sequences.
module tb_pwm_fade_controller;

    localparam int CHANNELS  = 3;
    localparam int BIT_WIDTH = 3;
    localparam int RATE_W    = 8;

    logic                          clk;
    logic                          rst_n;
    logic [BIT_WIDTH-1:0]          pwm_counter;
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [1:0]                    cfg_chan;
    logic [BIT_WIDTH-1:0]          cfg_target;
    logic [RATE_W-1:0]             cfg_rate;
    logic                          cfg_max_wr;
    logic [BIT_WIDTH-1:0]          cfg_max;
    logic [BIT_WIDTH-1:0]          max_value;
    logic [CHANNELS*BIT_WIDTH-1:0] duty_out;
    logic [CHANNELS-1:0]           busy;
`ifdef PWM_FADE_DONE_EN
    logic [CHANNELS-1:0]           fade_done;
`endif

    int checks = 0;
    int errors = 0;

    pwm_fade_controller #(
        .CHANNELS (CHANNELS),
        .BIT_WIDTH(BIT_WIDTH),
        .RATE_W   (RATE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_counter(pwm_counter),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_target (cfg_target),
        .cfg_rate   (cfg_rate),
        .cfg_max_wr (cfg_max_wr),
        .cfg_max    (cfg_max),
        .max_value  (max_value),
        .duty_out   (duty_out),
        .busy       (busy)
`ifdef PWM_FADE_DONE_EN
        ,
        .fade_done  (fade_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] chan;
        logic [2:0] target;
        logic [7:0] rate;
        logic       max_wr;
        logic [2:0] max_in;
        logic [2:0] cnt;
        logic [2:0] d0, d1, d2;
        logic [2:0] busy;
        logic [2:0] max_exp;
        logic       ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic valid, input logic [1:0] chan, input logic [2:0] target,
                               input logic [7:0] rate, input logic max_wr, input logic [2:0] max_in,
                               input logic [2:0] cnt, input logic [2:0] d0, input logic [2:0] d1,
                               input logic [2:0] d2, input logic [2:0] bsy, input logic [2:0] max_exp,
                               input logic ready);
        vec_t r;
        r.valid = valid; r.chan = chan; r.target = target; r.rate = rate;
        r.max_wr = max_wr; r.max_in = max_in; r.cnt = cnt;
        r.d0 = d0; r.d1 = d1; r.d2 = d2; r.busy = bsy; r.max_exp = max_exp; r.ready = ready;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive_idle(input logic [2:0] cnt);
        cfg_valid   = 1'b0;
        cfg_chan    = '0;
        cfg_target  = '0;
        cfg_rate    = '0;
        cfg_max_wr  = 1'b0;
        cfg_max     = '0;
        pwm_counter = cnt;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_duty"}, 32'(duty_out), 32'h0);
        check({tag, "_max"}, 32'(max_value), 32'h7);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_ready"}, 32'(cfg_ready), 32'h0);
`ifdef PWM_FADE_DONE_EN
        check({tag, "_done"}, 32'(fade_done), 32'h0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle(3'd1);

        //                 val ch tgt rate mwr max cnt  d0 d1 d2 busy     max rdy
        // Test 1: ch0 0->5 at rate 0, ch1 0->6 riding along
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3'b000, 7, 1));
        vecs.push_back(v(1, 0, 5, 0, 0, 0, 1,  0, 0, 0, 3'b001, 7, 1));
        vecs.push_back(v(1, 1, 6, 0, 0, 0, 1,  0, 0, 0, 3'b011, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 3'b011, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  2, 2, 0, 3'b011, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3,  2, 2, 0, 3'b011, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  3, 3, 0, 3'b011, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  4, 4, 0, 3'b011, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 5, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 6, 0, 3'b000, 7, 1));
        // Test 2: ch1 6->2 at rate 2, one step per three periods
        vecs.push_back(v(1, 1, 2, 2, 0, 0, 1,  5, 6, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 5, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 5, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 5, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 4, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 4, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 4, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 3, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 3, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 3, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 2, 0, 3'b000, 7, 1));
        // Test 3: ch2 fading to 7, max write of 4 mid-fade; command while not ready is ignored
        vecs.push_back(v(1, 2, 7, 0, 0, 0, 1,  5, 2, 0, 3'b100, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 2, 1, 3'b100, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  5, 2, 2, 3'b100, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 4, 1,  5, 2, 2, 3'b100, 7, 0));
        vecs.push_back(v(1, 1, 7, 0, 0, 0, 1,  5, 2, 2, 3'b100, 7, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  4, 2, 3, 3'b100, 4, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  4, 2, 3, 3'b100, 4, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 4,  4, 2, 4, 3'b000, 4, 1));
        // Test 4: retarget ch0 in a wrap cycle mid-fade; pending step is dropped
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  4, 2, 4, 3'b001, 4, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 4,  3, 2, 4, 3'b001, 4, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 4,  2, 2, 4, 3'b001, 4, 1));
        vecs.push_back(v(1, 0, 3, 0, 0, 0, 4,  2, 2, 4, 3'b001, 4, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 4,  3, 2, 4, 3'b000, 4, 1));
        // Test 5: max 3, target clamp, out-of-range channel dropped
        vecs.push_back(v(0, 0, 0, 0, 1, 3, 1,  3, 2, 4, 3'b000, 4, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 4,  3, 2, 3, 3'b000, 3, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  3, 2, 3, 3'b000, 3, 1));
        vecs.push_back(v(1, 1, 6, 0, 0, 0, 1,  3, 2, 3, 3'b010, 3, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3,  3, 3, 3, 3'b000, 3, 1));
        vecs.push_back(v(1, 3, 0, 0, 0, 0, 1,  3, 3, 3, 3'b000, 3, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3,  3, 3, 3, 3'b000, 3, 1));
        // Command and max write in one cycle: command clamps against the old max (3)
        vecs.push_back(v(1, 2, 5, 0, 1, 7, 1,  3, 3, 3, 3'b000, 3, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3,  3, 3, 3, 3'b000, 7, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  3, 3, 3, 3'b000, 7, 1));
        // max_value 0: duties forced to 0, commands complete immediately
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 1,  3, 3, 3, 3'b000, 7, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  0, 0, 0, 3'b000, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3'b000, 0, 1));
        vecs.push_back(v(1, 0, 5, 0, 0, 0, 1,  0, 0, 0, 3'b000, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 3'b000, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 7, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3'b000, 7, 1));
        // Start a slow fade on ch1 to be interrupted by reset
        vecs.push_back(v(1, 1, 7, 3, 0, 0, 1,  0, 0, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  0, 1, 0, 3'b010, 7, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7,  0, 1, 0, 3'b010, 7, 1));

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        #2 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_valid   = vecs[i].valid;
            cfg_chan    = vecs[i].chan;
            cfg_target  = vecs[i].target;
            cfg_rate    = vecs[i].rate;
            cfg_max_wr  = vecs[i].max_wr;
            cfg_max     = vecs[i].max_in;
            pwm_counter = vecs[i].cnt;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_duty", i), 32'(duty_out), 32'({vecs[i].d2, vecs[i].d1, vecs[i].d0}));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d_max", i), 32'(max_value), 32'(vecs[i].max_exp));
            check($sformatf("v%0d_ready", i), 32'(cfg_ready), 32'(vecs[i].ready));
        end

        // Test 6: asynchronous reset between edges mid-fade
        drive_idle(3'd1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        pwm_counter = 3'd7;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("held_rst");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(cfg_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_duty%0d", k), 32'(duty_out), 32'h0);
            check($sformatf("post_rst_busy%0d", k), 32'(busy), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
